serial_rx: RTL and testbench
============================

# serial_rx

Asynchronous 8N1 serial receiver that sits directly upstream of the serial_fpga command parser. It takes the raw `rxd` pin and synchronises it into the `clk` domain. It locates each frame by mid-bit sampling and hands every completed byte downstream over a valid/ready handshake. Framing errors and overruns are flagged as single-cycle pulses.

## Interface
- `CLK_FREQUENCY`, 50_000_000: `clk` frequency in Hz.
- `BAUD`, 115_200: line rate in bit/s.
- `DBUS_WIDTH`, 8: data bits per frame and width of `rx_data`.
- Derived: N = CLK_FREQUENCY/BAUD (integer division; 434 at defaults); H = N/2 (217).

Ports:
- `clk`, in, 1: single clock; all logic runs on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `rxd`, in, 1: raw serial line; idles high; asynchronous to `clk`.
- `rx_data`, out, DBUS_WIDTH: received byte, LSB first on the line.
- `rx_valid`, out, 1: `rx_data` holds an unconsumed byte.
- `rx_ready`, in, 1: consumer accepts the byte this cycle.
- `frame_err`, out, 1: one-cycle pulse; stop bit sampled low.
- `overrun`, out, 1: one-cycle pulse; a byte was dropped because the holding register was full.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- **Synchroniser.** `rxd` passes through 2 flops; the output is `rxs`. Both flops reset to 1.
- **IDLE.** Waits for `rxs` = 0, then loads the bit counter with H−1 and goes to START.
- **START.** Counts down to 0 and samples `rxs`.
  - `rxs` = 1: false start; return to IDLE with no flags.
  - `rxs` = 0: load the counter with N−1 and go to DATA, bit index 0.
- **DATA.** Each time the counter reaches 0, shift `rxs` into bit [index] of the shift register and reload N−1. After DBUS_WIDTH bits, go to STOP.
- **STOP.** Samples at counter 0.
  - `rxs` = 1: deliver the byte (see the holding register rules below), then go to IDLE.
  - `rxs` = 0: pulse `frame_err`, discard the byte, go to BREAK.
- **BREAK.** Waits for `rxs` = 1, then goes to IDLE. This prevents a held-low line from restarting frames.
- **Holding register.** One entry, driving `rx_data` and `rx_valid`.
  - Handshake completes on a cycle with `rx_valid` & `rx_ready`.
  - `rx_data` is stable while `rx_valid` = 1.
  - Delivery with `rx_valid` = 0: load the byte and set `rx_valid`.
  - Delivery with `rx_valid` = 1 and `rx_ready` = 0: pulse `overrun`; the new byte is dropped and the old byte is kept.
  - Delivery and handshake on the same cycle: the new byte is loaded and `rx_valid` stays 1; no overrun.
- **Counter width.** $clog2(N) bits. The counter never wraps; it is always reloaded explicitly.

## Timing
- **Reset values.** `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0; state IDLE; synchroniser flops = 1.
- **Reset mid-frame.** Takes effect immediately (asynchronous); the partial byte is lost; no flags are raised.
- **Sample points.** Cycle 0 is the first edge at which the first synchroniser flop captures 0.
  - Start bit is sampled at cycle 2+H.
  - Data bit k (k = 0..7) is sampled at 2+H+(k+1)·N.
  - Stop bit is sampled at 2+H+9·N.
- **Delivery latency.** `rx_valid` rises, or `frame_err`/`overrun` pulses, on the edge after the stop sample. At defaults that is cycle 4126.
- **`busy`.** Rises at cycle 3 and falls together with the delivery edge.
- **Back-to-back frames.** A new start bit detected in IDLE on the cycle after the stop sample is handled normally. Tolerated baud mismatch is about ±4 %.
- **`rx_valid` fall.** Falls on the edge after a handshake, unless a delivery happens on that same cycle.

## Structure
- **Shared package/include `serial_defs`.** Holds:
  - state encodings: IDLE, START, DATA, STOP, BREAK;
  - N/H derivation macros, so the transmitter and bench reuse them.
- **Sub-module `input_sync`.** Parameterised 2-flop synchroniser with a reset value parameter, reused for GPIO inputs.
- **Main body.** FSM, counter, shift register and holding register stay in `serial_rx`.

## Test plan
1. **Single byte.** Send 0xA5 at the nominal rate with `rx_ready` = 1 → `rx_valid` is high for exactly 1 cycle at cycle 4126, `rx_data` = 0xA5, no flags.
2. **False start.** Pulse `rxd` low for 100 cycles → returns to IDLE; `busy` falls by cycle 220; no `rx_valid`, no `frame_err`.
3. **Framing error.** Send 0x3C with the stop bit low, then hold the line low for 2000 cycles → `frame_err` pulses once and `rx_valid` stays 0. After the line returns high, 0x55 is received correctly.
4. **Overrun.** Send 0x11 then 0x22 with `rx_ready` = 0 → `rx_data` stays 0x11 and `overrun` pulses once at the second stop. Raising `rx_ready` then gives one handshake on 0x11.
5. **Simultaneous handshake.** Assert `rx_ready` exactly on the delivery cycle of the second byte → no overrun; `rx_data` changes to the second byte with `rx_valid` continuously 1.
6. **Reset mid-frame.** Assert `reset` low during DATA bit 3 → all outputs are 0 immediately. The next full frame, 0xFF, is received correctly.

Source files
------------

// File: rtl/serial_defs_pkg.sv
// Shared definitions for the serial link: receiver state encoding and bit-timing helpers.
// The transmitter and benches reuse the divisor functions so all sides agree on N and H.
package serial_defs_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // Clock cycles per bit (N).
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Half-bit offset (H) used to land the first sample mid start bit.
  function automatic int unsigned half_div(input int unsigned clk_hz, input int unsigned baud);
    return baud_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset level.
module input_sync #(
  parameter int unsigned Width    = 1,
  parameter logic        ResetVal = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= {Width{ResetVal}};
      q      <= {Width{ResetVal}};
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// 8N1 serial receiver: mid-bit sampling FSM feeding a one-entry valid/ready holding register.
// Delivery, frame_err and overrun all appear one edge after the stop-bit sample.
module serial_rx
  import serial_defs_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50_000_000,
  parameter int unsigned BAUD          = 115_200,
  parameter int unsigned DBUS_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  output logic [DBUS_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned N    = baud_div(CLK_FREQUENCY, BAUD);
  localparam int unsigned H    = half_div(CLK_FREQUENCY, BAUD);
  localparam int unsigned CntW = $clog2(N);
  localparam int unsigned IdxW = (DBUS_WIDTH > 1) ? $clog2(DBUS_WIDTH) : 1;

  localparam logic [CntW-1:0] BitReload  = CntW'(N - 1);
  localparam logic [CntW-1:0] HalfReload = CntW'(H - 1);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(DBUS_WIDTH - 1);

  logic rxs;

  input_sync #(
    .Width    (1),
    .ResetVal (1'b1)
  ) u_input_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxs)
  );

  rx_state_e             state_q;
  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [DBUS_WIDTH-1:0] shift_q;
  logic                  stop_ok_q;
  logic                  stop_bad_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      stop_ok_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      busy       <= 1'b0;
    end else begin
      stop_ok_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      busy       <= (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (!rxs) begin
            cnt_q   <= HalfReload;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rxs) begin
            state_q <= StIdle;
          end else begin
            cnt_q   <= BitReload;
            idx_q   <= '0;
            state_q <= StData;
          end
        end
        StData: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q[idx_q] <= rxs;
            cnt_q          <= BitReload;
            if (idx_q == LastIdx) begin
              state_q <= StStop;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rxs) begin
            stop_ok_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            stop_bad_q <= 1'b1;
            state_q    <= StBreak;
          end
        end
        StBreak: begin
          // Hold off until the line recovers so a stuck-low line cannot spawn frames.
          if (rxs) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad_q;
      overrun   <= 1'b0;
      if (stop_ok_q) begin
        // A handshake on the delivery cycle frees the slot for the new byte.
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: scoreboard of expected bytes plus cycle-exact timing checks.
module tb_serial_rx;

  localparam int unsigned N = 434;
  localparam int unsigned H = 217;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  serial_rx #(
    .CLK_FREQUENCY (50_000_000),
    .BAUD          (115_200),
    .DBUS_WIDTH    (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collects handshaken bytes and event timestamps on the falling edge.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int valid_cycles  = 0;
  int err_cnt       = 0;
  int ovr_cnt       = 0;
  int rise_cyc      = -1;
  int err_cyc       = -1;
  int busy_rise_cyc = -1;
  int busy_fall_cyc = -1;
  logic prev_valid  = 1'b0;
  logic prev_busy   = 1'b0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    if (busy && !prev_busy) busy_rise_cyc <= cyc;
    if (!busy && prev_busy) busy_fall_cyc <= cyc;
    if (frame_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    prev_valid <= rx_valid;
    prev_busy  <= busy;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered and left at posedge+1; the first sync flop sees the start bit on the next edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    idle(N);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(N);
    end
    rxd = stop_bit;
    idle(N);
  endtask

  task automatic drain_sb(input string tag);
    logic [7:0] g;
    logic [7:0] e;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, int'(g), int'(e));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  int s;
  int sb;
  int err0;
  int ovr0;
  int vc0;

  initial begin
    reset    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", int'(rx_data), 0);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_flags", int'({frame_err, overrun}), 0);
    reset = 1'b1;
    idle(20);

    // Single byte with consumer always ready.
    s = cyc + 1;
    err0 = err_cnt; ovr0 = ovr_cnt; vc0 = valid_cycles;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(50);
    check("single_valid_rise", rise_cyc, s + 4126);
    check("single_valid_len", valid_cycles - vc0, 1);
    check("single_busy_rise", busy_rise_cyc, s + 3);
    check("single_busy_fall", busy_fall_cyc, s + 4126);
    check("single_no_err", err_cnt - err0, 0);
    check("single_no_ovr", ovr_cnt - ovr0, 0);
    drain_sb("single");

    // False start: 100-cycle glitch.
    s = cyc + 1;
    err0 = err_cnt; vc0 = valid_cycles;
    rxd = 1'b0;
    idle(100);
    rxd = 1'b1;
    wait_until(s + 220);
    check("fs_busy_low", int'(busy), 0);
    idle(30);
    check("fs_busy_fall", busy_fall_cyc, s + 220);
    idle(4500);
    check("fs_no_valid", valid_cycles - vc0, 0);
    check("fs_no_err", err_cnt - err0, 0);

    // Framing error followed by a held-low line, then a good frame.
    s = cyc + 1;
    err0 = err_cnt; vc0 = valid_cycles;
    send_frame(8'h3C, 1'b0);
    idle(2000);
    check("ferr_pulses", err_cnt - err0, 1);
    check("ferr_cycle", err_cyc, s + 4126);
    check("ferr_no_valid", valid_cycles - vc0, 0);
    check("ferr_break_busy", int'(busy), 1);
    rxd = 1'b1;
    idle(50);
    check("ferr_idle_again", int'(busy), 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(50);
    check("ferr_recover_err", err_cnt - err0, 1);
    drain_sb("ferr_recover");

    // Overrun: two bytes with nobody consuming.
    rx_ready = 1'b0;
    ovr0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(50);
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    check("ovr_data_kept", int'(rx_data), 8'h11);
    check("ovr_valid", int'(rx_valid), 1);
    check("ovr_no_hs", got_q.size(), 0);
    rx_ready = 1'b1;
    idle(5);
    check("ovr_valid_fall", int'(rx_valid), 0);
    drain_sb("ovr");

    // Handshake coinciding with the second delivery.
    rx_ready = 1'b0;
    ovr0 = ovr_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check("sim_first_valid", int'(rx_valid), 1);
    check("sim_first_data", int'(rx_data), 8'h5A);
    exp_q.push_back(8'hC3);
    sb = cyc + 1;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        wait_until(sb + 4125);
        check("sim_pre_valid", int'(rx_valid), 1);
        check("sim_pre_data", int'(rx_data), 8'h5A);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check("sim_post_valid", int'(rx_valid), 1);
        check("sim_post_data", int'(rx_data), 8'hC3);
      end
    join
    idle(20);
    check("sim_no_ovr", ovr_cnt - ovr0, 0);
    check("sim_one_hs", got_q.size(), 1);
    rx_ready = 1'b1;
    idle(5);
    drain_sb("sim");

    // Reset in the middle of data bit 3.
    s = cyc + 1;
    err0 = err_cnt; ovr0 = ovr_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_until(s + 2 + H + 3 * N + 100);
        check("mid_busy_before", int'(busy), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_data", int'(rx_data), 0);
        check("mid_rst_valid", int'(rx_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_flags", int'({frame_err, overrun}), 0);
        idle(3);
        reset = 1'b1;
      end
    join
    idle(100);
    check("mid_no_delivery", got_q.size(), 0);
    check("mid_no_flags", (err_cnt - err0) + (ovr_cnt - ovr0), 0);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    idle(50);
    drain_sb("mid_next");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
